sequencer_fsm: RTL and testbench



---
 rtl/sequencer_pkg.sv | 16 +
 rtl/seq_buffer.sv | 49 ++++
 rtl/sequencer_fsm.sv | 136 +++++++++++++
 tb/tb_sequencer_fsm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// Shared types and command bytes for the record/replay sequencer.
package sequencer_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_REPLAY = 2'd2
  } state_t;

  localparam byte_t CMD_STOP   = 8'h30;
  localparam byte_t CMD_RECORD = 8'h31;
  localparam byte_t CMD_REPLAY = 8'h32;

endpackage

// File: rtl/seq_buffer.sv
// DEPTH x 8 record buffer: synchronous append-only write, combinational read.
// Writes past DEPTH are dropped; the fill length is exported to the FSM.
module seq_buffer
  import sequencer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_wr_en,
  input  byte_t                    i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output byte_t                    o_rd_data,
  output logic [$clog2(DEPTH):0]   o_length
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  byte_t          r_mem [DEPTH];
  logic [LW-1:0]  r_length;
  logic           w_full;
  logic           w_write;

  assign w_full  = (r_length == LW'(DEPTH));
  assign w_write = i_wr_en && !w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_length <= '0;
    end else if (i_clr) begin
      r_length <= '0;
    end else if (w_write) begin
      r_length <= r_length + LW'(1);
    end
  end

  // Contents carry no reset; nothing at or beyond r_length is ever read.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_length[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];
  assign o_length  = r_length;

endmodule

// File: rtl/sequencer_fsm.sv
// Byte-command record/replay sequencer: IDLE/RECORD/REPLAY FSM with registered outputs.
// Define SEQUENCER_LOOP_EN to loop replay passes until a stop byte; otherwise one pass.
module sequencer_fsm
  import sequencer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] data,
  output logic       replay_start,
  output logic       replay_en,
  output logic       record_en,
  output logic [7:0] replay_data,
  output logic       replay_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  state_t         r_state;
  logic [LW-1:0]  r_rd_idx;
  logic [SW-1:0]  r_step;

  logic           w_clr;
  logic           w_wr_en;
  logic [AW-1:0]  w_rd_addr;
  byte_t          w_rd_data;
  logic [LW-1:0]  w_length;
  logic           w_stop;

  assign w_stop  = ready && (data == CMD_STOP);
  assign w_clr   = (r_state == ST_IDLE) && ready && (data == CMD_RECORD);
  assign w_wr_en = (r_state == ST_RECORD) && ready && (data != CMD_STOP);

  // Past the end of a pass the address falls back to 0 so a wrap reads buffer[0].
  assign w_rd_addr = ((r_state == ST_REPLAY) && (r_rd_idx < w_length)) ?
                     r_rd_idx[AW-1:0] : '0;

  seq_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_wr_en   (w_wr_en),
    .i_wr_data (data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data),
    .o_length  (w_length)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rd_idx     <= '0;
      r_step       <= '0;
      replay_start <= 1'b0;
      replay_en    <= 1'b0;
      record_en    <= 1'b0;
      replay_data  <= 8'h00;
      replay_valid <= 1'b0;
    end else begin
      replay_start <= 1'b0;
      replay_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ready && (data == CMD_RECORD)) begin
            r_state   <= ST_RECORD;
            record_en <= 1'b1;
          end else if (ready && (data == CMD_REPLAY)) begin
            r_state      <= ST_REPLAY;
            replay_en    <= 1'b1;
            replay_start <= 1'b1;
            r_step       <= '0;
            if (w_length != '0) begin
              replay_valid <= 1'b1;
              replay_data  <= w_rd_data;
              r_rd_idx     <= LW'(1);
            end else begin
              r_rd_idx <= '0;
            end
          end
        end
        ST_RECORD: begin
          if (w_stop) begin
            r_state   <= ST_IDLE;
            record_en <= 1'b0;
          end
        end
        ST_REPLAY: begin
          if (w_stop) begin
            r_state   <= ST_IDLE;
            replay_en <= 1'b0;
            r_rd_idx  <= '0;
            r_step    <= '0;
          end else if (r_step == STEP_LAST) begin
            r_step <= '0;
            if (r_rd_idx < w_length) begin
              replay_valid <= 1'b1;
              replay_data  <= w_rd_data;
              r_rd_idx     <= r_rd_idx + LW'(1);
            end else begin
`ifdef SEQUENCER_LOOP_EN
              replay_start <= 1'b1;
              if (w_length != '0) begin
                replay_valid <= 1'b1;
                replay_data  <= w_rd_data;
                r_rd_idx     <= LW'(1);
              end else begin
                r_rd_idx <= '0;
              end
`else
              r_state   <= ST_IDLE;
              replay_en <= 1'b0;
              r_rd_idx  <= '0;
`endif
            end
          end else begin
            r_step <= r_step + SW'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          replay_en <= 1'b0;
          record_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequencer_fsm.sv
// Directed bench for sequencer_fsm (DEPTH=16, STEP_CYCLES=4); follows SEQUENCER_LOOP_EN if defined.
module tb_sequencer_fsm;

  localparam int DEPTH = 16;
  localparam int STEP  = 4;
  localparam int NVEC  = 19;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [7:0] data;
  logic       replay_start;
  logic       replay_en;
  logic       record_en;
  logic [7:0] replay_data;
  logic       replay_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rdy;
    logic [7:0] din;
    logic       rec;
    logic       rep;
    logic       st;
    logic       vl;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [NVEC];

  sequencer_fsm #(
    .DEPTH       (DEPTH),
    .STEP_CYCLES (STEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .data         (data),
    .replay_start (replay_start),
    .replay_en    (replay_en),
    .record_en    (record_en),
    .replay_data  (replay_data),
    .replay_valid (replay_valid)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [7:0] d, input logic rec,
                              input logic rep, input logic st, input logic vl,
                              input logic [7:0] dout);
    vec_t v;
    v.rdy = r; v.din = d; v.rec = rec; v.rep = rep; v.st = st; v.vl = vl; v.dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%02h required=0x%02h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rec, input logic rep, input logic st,
                         input logic vl, input logic chk_d, input logic [7:0] dout);
    chk({tag, ".record_en"},    {7'd0, record_en},    {7'd0, rec});
    chk({tag, ".replay_en"},    {7'd0, replay_en},    {7'd0, rep});
    chk({tag, ".replay_start"}, {7'd0, replay_start}, {7'd0, st});
    chk({tag, ".replay_valid"}, {7'd0, replay_valid}, {7'd0, vl});
    if (chk_d) chk({tag, ".replay_data"}, replay_data, dout);
  endtask

  // One input cycle: drive, clock, then sample 1 time unit after the edge.
  task automatic tick(input logic r, input logic [7:0] d);
    ready = r;
    data  = d;
    @(posedge clk);
    #1;
    ready = 1'b0;
    data  = 8'h00;
  endtask

  initial begin
    logic [7:0] exp_d;
    vecs[0]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[1]  = mk(1'b1, 8'h31, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[2]  = mk(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[3]  = mk(1'b1, 8'h31, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[4]  = mk(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[5]  = mk(1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[7]  = mk(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[8]  = mk(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[9]  = mk(1'b1, 8'h32, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41);
    vecs[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41);
    vecs[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41);
    vecs[12] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41);
    vecs[13] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h42);
    vecs[14] = mk(1'b1, 8'h35, 1'b0, 1'b1, 1'b0, 1'b0, 8'h42);
    vecs[15] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h42);
    vecs[16] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h42);
`ifdef SEQUENCER_LOOP_EN
    vecs[17] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41);
    vecs[18] = mk(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41);
`else
    vecs[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42);
    vecs[18] = mk(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42);
`endif

    rst = 1'b1; ready = 1'b0; data = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      tick(vecs[i].rdy, vecs[i].din);
      $display("vec %0d: ready=%0b data=%02h -> rec=%0b rep=%0b st=%0b vl=%0b out=%02h",
               i, vecs[i].rdy, vecs[i].din, record_en, replay_en, replay_start,
               replay_valid, replay_data);
      chk_out($sformatf("vec%0d", i), vecs[i].rec, vecs[i].rep, vecs[i].st, vecs[i].vl,
              1'b1, vecs[i].dout);
    end

    // Command codes recorded as plain data.
    tick(1'b1, 8'h31); tick(1'b1, 8'h31); tick(1'b1, 8'h32); tick(1'b1, 8'h30);
    tick(1'b1, 8'h32);
    $display("cmd-as-data: entered replay");
    chk_out("cmddata.b0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h31);
    for (int k = 1; k < STEP; k++) tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    chk_out("cmddata.b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h32);
    tick(1'b1, 8'h30);
    chk_out("cmddata.stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h32);

    // Overflow: DEPTH+3 bytes recorded, only the first DEPTH replay.
    tick(1'b1, 8'h31);
    for (int k = 0; k < DEPTH + 3; k++) tick(1'b1, 8'h50 + 8'(k));
    tick(1'b1, 8'h30);
    tick(1'b1, 8'h32);
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0) begin
        for (int j = 1; j < STEP; j++) tick(1'b0, 8'h00);
        chk_out($sformatf("ovf.gap%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h50 + 8'(k - 1));
        tick(1'b0, 8'h00);
      end
      $display("overflow: byte %0d out=%02h", k, replay_data);
      chk_out($sformatf("ovf.b%0d", k), 1'b0, 1'b1, (k == 0), 1'b1, 1'b1, 8'h50 + 8'(k));
    end
    for (int j = 0; j < STEP; j++) tick(1'b0, 8'h00);
`ifdef SEQUENCER_LOOP_EN
    chk_out("ovf.end", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h50);
    exp_d = 8'h50;
`else
    chk_out("ovf.end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5F);
    exp_d = 8'h5F;
`endif
    tick(1'b1, 8'h30);
    chk_out("ovf.stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_d);

    // Empty buffer replay, stop byte five cycles after entry.
    tick(1'b1, 8'h31); tick(1'b1, 8'h30);
    tick(1'b1, 8'h32);
    $display("empty: entered replay");
    chk_out("empty.entry", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, exp_d);
    for (int k = 1; k <= 4; k++) begin
      tick(1'b0, 8'h00);
`ifdef SEQUENCER_LOOP_EN
      chk_out($sformatf("empty.c%0d", k), 1'b0, 1'b1, (k == STEP), 1'b0, 1'b1, exp_d);
`else
      chk_out($sformatf("empty.c%0d", k), 1'b0, (k < STEP), 1'b0, 1'b0, 1'b1, exp_d);
`endif
    end
    tick(1'b1, 8'h30);
    chk_out("empty.stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_d);

    // Reset in the middle of a replay.
    tick(1'b1, 8'h31); tick(1'b1, 8'h77); tick(1'b1, 8'h30);
    tick(1'b1, 8'h32);
    chk_out("rstmid.entry", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
    tick(1'b0, 8'h00);
    rst = 1'b1;
    tick(1'b0, 8'h00);
    rst = 1'b0;
    $display("reset mid-replay applied");
    chk_out("rstmid.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(1'b1, 8'h32);
    chk_out("rstmid.replay", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(1'b1, 8'h30);
    chk_out("rstmid.stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
